routing_tree_dispatcher: RTL and testbench
==========================================

Name: routing_tree_dispatcher

Overview:
- Front-end scheduler for the activation routing tree.
- Accepts one activation stream over a valid/ready handshake and picks a destination PE output round-robin over a configurable enable mask (the workload-balancing assignment).
- Tracks per-output credits, so the tree never overruns a PE input buffer.
- Drives the tree's input word and routing code, and emits a one-hot output-valid vector aligned with the tree's outputs. This makes a zero-valued activation distinguishable from an idle slot.

Parameters:
INPUT_WORD_BIT_WIDTH, 8, activation width (matches tree)
NUMBER_OF_ROUTING_TREE_OUTPUTS, 16, tree outputs / PEs; power of two >= 2
CREDIT_DEPTH, 4, per-output PE buffer depth; initial and maximum credit
ROUTING_CODE_BIT_WIDTH (localparam), $clog2(NUMBER_OF_ROUTING_TREE_OUTPUTS)
NUMBER_OF_ROUTING_TREE_LEVELS (localparam), $clog2(NUMBER_OF_ROUTING_TREE_OUTPUTS)

Ports:
clk  in  1  single clock
resetn  in  1  synchronous reset, active-low
i_config_valid  in  1  load new enable mask
i_output_enable_mask  in  NUMBER_OF_ROUTING_TREE_OUTPUTS  bit k=1: output k participates
i_input_valid  in  1  activation available
i_input  in  INPUT_WORD_BIT_WIDTH  activation word
o_input_ready  out  1  dispatcher accepts i_input this cycle
i_credit_return  in  NUMBER_OF_ROUTING_TREE_OUTPUTS  bit k: PE k freed one buffer slot
o_tree_input  out  INPUT_WORD_BIT_WIDTH  to tree i_input
o_tree_routing_code  out  ROUTING_CODE_BIT_WIDTH  to tree i_routing_code
o_tree_valid  out  1  tree input carries a real word
o_output_valid  out  NUMBER_OF_ROUTING_TREE_OUTPUTS  one-hot, aligned with tree o_outputs
o_stall  out  1  in STALL state
o_credit_overflow  out  1  sticky: credit returned while already at CREDIT_DEPTH
o_dispatch_count  out  32  words dispatched since reset, wraps

Behaviour:
- Interface: one clock domain on clk. resetn is synchronous and active-low.
- Reset (resetn==0 at posedge):
  - mask = all ones; every credit = CREDIT_DEPTH; pointer = 0; state = IDLE.
  - All outputs = 0, including o_input_ready, the o_output_valid pipeline, o_credit_overflow and o_dispatch_count.
- Reset mid-operation: in-flight o_output_valid bits are cleared. The tree is reset in the same cycle, so alignment holds.
- States:
  - IDLE: mask==0, or no valid input.
  - RUN: dispatching.
  - STALL: i_input_valid=1 but credit[ptr]==0.
  - Transitions are evaluated each cycle from registered mask, pointer and credits. STALL->RUN on the cycle after credit[ptr] becomes >0.
- o_input_ready (combinational from registers) = (mask!=0) && (credit[ptr]>0) && !i_config_valid.
- Transfer occurs when i_input_valid && o_input_ready. On transfer:
  - Next cycle: o_tree_input=i_input, o_tree_routing_code=ptr, o_tree_valid=1. Otherwise o_tree_input=0 and o_tree_valid=0.
  - credit[ptr] decrements.
  - ptr advances to the next set mask bit strictly after ptr, wrapping modulo N. A single-bit mask keeps ptr unchanged.
  - o_dispatch_count increments.
- Pointer never skips on stall: order is strict round-robin, and the dispatcher waits for the credit of the current target.
- Config: when i_config_valid=1, the mask is loaded at the posedge and ptr is set to the lowest set bit of the new mask (0 if the mask is 0). No transfer happens that cycle. Credits are unchanged. In-flight words complete normally.
- Credit return: each bit of i_credit_return adds 1 to that output's credit, in parallel for all outputs.
  - Return and decrement on the same output in the same cycle: net unchanged.
  - Return at CREDIT_DEPTH with no same-cycle decrement: credit stays at CREDIT_DEPTH and o_credit_overflow sets. It stays set until reset.
- Credit counter width: $clog2(CREDIT_DEPTH+1).
- Valid alignment:
  - o_output_valid = one-hot(o_tree_routing_code) gated by o_tree_valid, delayed NUMBER_OF_ROUTING_TREE_LEVELS cycles.
  - Total latency from accept to PE data/valid = 1 + NUMBER_OF_ROUTING_TREE_LEVELS cycles (5 for N=16).
  - Throughput: one word per cycle while credits allow.
- o_stall = (state==STALL).

Optional Feature:
- Macro: ROUTING_DISPATCH_ZERO_SKIP_EN.
- Defined:
  - An accepted word equal to 0 is consumed (handshake completes, o_input_ready still requires credit[ptr]>0) but not dispatched.
  - No o_tree_valid, no credit decrement, no pointer advance, no count increment.
  - Adds output o_skip_count (32, wraps) counting skipped words.
- Undefined: zeros are dispatched like any word. o_skip_count is absent.

Test Plan:
- Reset, mask all ones, 16 back-to-back words 1..16 -> codes 0..15 in order, o_output_valid[k] one-hot 5 cycles after each accept, PE k sees k+1, o_dispatch_count=16.
- Mask 16'h0011, no credit returns, 10 words -> alternate outputs 0,4; after 8 accepts o_input_ready=0 and o_stall=1; return credit to output 0 -> one more word accepted to output 0, then stall again.
- Mask 16'h0000 -> o_input_ready=0 indefinitely. Then load 16'h0100 -> ptr=8, next word routed to output 8.
- Credit return on output 3 while a word to output 3 is dispatched in the same cycle with credit=2 -> credit stays 2. Return to an output at 4 -> o_credit_overflow=1 and held.
- Assert resetn=0 with 3 words in flight -> o_output_valid all 0 next cycle, credits back to 4, no late valids appear.
- With ROUTING_DISPATCH_ZERO_SKIP_EN defined: input 0,5,0,7 -> only 5 and 7 dispatched to outputs 0,1; o_skip_count=2, o_dispatch_count=2.

Source files
------------

// File: rtl/routing_tree_dispatcher.sv
// routing_tree_dispatcher
// ----------------------------------------------------------------------------
// Front-end scheduler for the activation routing tree. Accepts one activation
// stream (valid/ready) and assigns each word round-robin to one of the enabled
// PE outputs. It keeps one credit counter per PE so that a PE input buffer is
// never overrun. It also produces a one-hot output-valid vector that lines up
// with the tree outputs, so a zero activation can be told apart from an idle slot.
//
// Handshake: a word moves from the producer into the dispatcher on a rising
// clk edge where i_input_valid && o_input_ready. o_input_ready depends only on
// registered state, i_config_valid and resetn. It never depends on
// i_input_valid. The producer must hold i_input stable while i_input_valid=1
// and the word is not yet accepted.
//
// Optional feature macro: ROUTING_DISPATCH_ZERO_SKIP_EN
//   When defined, accepted zero words are consumed without being dispatched,
//   and o_skip_count counts them.
//
// Ports:
//   clk, resetn            single clock; synchronous active-low reset
//   i_config_valid         load i_output_enable_mask this cycle (blocks transfer)
//   i_output_enable_mask   bit k=1 : output k takes part in round-robin
//   i_input_valid/i_input  activation stream in
//   o_input_ready          dispatcher accepts i_input this cycle
//   i_credit_return        bit k : PE k freed one buffer slot
//   o_tree_input           word presented to the tree
//   o_tree_routing_code    destination code presented to the tree
//   o_tree_valid           tree input carries a real word
//   o_output_valid         one-hot valid aligned with the tree outputs
//   o_stall                FSM is in STALL (waiting for credit of current target)
//   o_credit_overflow      sticky: credit returned to an already-full counter
//   o_dispatch_count       words dispatched since reset (wraps)
//   o_skip_count           zero words skipped since reset (feature only, wraps)
// ----------------------------------------------------------------------------
module routing_tree_dispatcher #(
    parameter int INPUT_WORD_BIT_WIDTH           = 8,
    parameter int NUMBER_OF_ROUTING_TREE_OUTPUTS = 16,
    parameter int CREDIT_DEPTH                   = 4
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      i_config_valid,
    input  logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0] i_output_enable_mask,
    input  logic                                      i_input_valid,
    input  logic [INPUT_WORD_BIT_WIDTH-1:0]           i_input,
    output logic                                      o_input_ready,
    input  logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0] i_credit_return,
    output logic [INPUT_WORD_BIT_WIDTH-1:0]           o_tree_input,
    output logic [$clog2(NUMBER_OF_ROUTING_TREE_OUTPUTS)-1:0] o_tree_routing_code,
    output logic                                      o_tree_valid,
    output logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0] o_output_valid,
    output logic                                      o_stall,
    output logic                                      o_credit_overflow,
    output logic [31:0]                               o_dispatch_count
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
    ,
    output logic [31:0]                               o_skip_count
`endif
);

    localparam int N   = NUMBER_OF_ROUTING_TREE_OUTPUTS;
    localparam int ROUTING_CODE_BIT_WIDTH        = $clog2(N);
    localparam int NUMBER_OF_ROUTING_TREE_LEVELS = $clog2(N);
    localparam int CW  = ROUTING_CODE_BIT_WIDTH;
    localparam int LV  = NUMBER_OF_ROUTING_TREE_LEVELS;
    localparam int CRW = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CRW-1:0] CREDIT_FULL = CRW'(CREDIT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N-1:0]                    r_mask;
    logic [CRW-1:0]                  r_credit [N];
    logic [CW-1:0]                   r_ptr;
    state_t                          r_state;
    logic [INPUT_WORD_BIT_WIDTH-1:0] r_tree_input;
    logic [CW-1:0]                   r_tree_code;
    logic                            r_tree_valid;
    logic [N-1:0]                    r_valid_pipe [LV];
    logic                            r_overflow;
    logic [31:0]                     r_dispatch_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t                          w_state_next;
    logic                            w_ready;
    logic                            w_transfer;
    logic                            w_dispatch;
    logic [CW-1:0]                   w_next_ptr;
    logic [CW-1:0]                   w_cfg_ptr;
    logic [N-1:0]                    w_dec_vec;
    logic [N-1:0]                    w_full_vec;
    logic                            w_overflow_event;
    logic [N-1:0]                    w_tree_onehot;

    // Reset gating keeps ready low while resetn is asserted even though the
    // reset register values would otherwise allow a transfer.
    assign w_ready    = resetn && (r_mask != '0) && (r_credit[r_ptr] != '0)
                        && !i_config_valid;
    assign w_transfer = i_input_valid && w_ready;

`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
    logic        w_skip;
    logic [31:0] r_skip_count;
    // Zero words complete the handshake but never reach the tree.
    assign w_skip     = w_transfer && (i_input == '0);
    assign w_dispatch = w_transfer && !w_skip;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_skip_count <= '0;
        end else if (w_skip) begin
            r_skip_count <= r_skip_count + 32'd1;
        end
    end

    assign o_skip_count = r_skip_count;
`else
    assign w_dispatch = w_transfer;
`endif

    // Next enabled output strictly after r_ptr, wrapping. The loop runs from
    // the farthest candidate to the nearest, so the nearest one wins. When no
    // other bit is set, the pointer stays put (single-bit mask case).
    always_comb begin
        w_next_ptr = r_ptr;
        for (int i = N - 1; i >= 1; i--) begin
            if (r_mask[r_ptr + CW'(i)]) begin
                w_next_ptr = r_ptr + CW'(i);
            end
        end
    end

    // Lowest set bit of the incoming mask, or 0 for an empty mask.
    always_comb begin
        w_cfg_ptr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_output_enable_mask[i]) begin
                w_cfg_ptr = CW'(i);
            end
        end
    end

    always_comb begin
        w_dec_vec  = '0;
        w_full_vec = '0;
        if (w_dispatch) begin
            w_dec_vec = N'(1) << r_ptr;
        end
        for (int k = 0; k < N; k++) begin
            w_full_vec[k] = (r_credit[k] == CREDIT_FULL);
        end
    end

    // An overflow is a return to a full counter that is not cancelled by a
    // dispatch to the same output in the same cycle.
    assign w_overflow_event = |(i_credit_return & ~w_dec_vec & w_full_vec);

    assign w_tree_onehot = r_tree_valid ? (N'(1) << r_tree_code) : '0;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        if ((r_mask != '0) && i_input_valid) begin
            w_state_next = (r_credit[r_ptr] == '0) ? ST_STALL : ST_RUN;
        end
    end

    always_comb begin
        o_stall = (r_state == ST_STALL);
    end

    // ------------------------------------------------------------------
    // Mask, pointer, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mask           <= '1;
            r_ptr            <= '0;
            r_overflow       <= 1'b0;
            r_dispatch_count <= '0;
        end else begin
            if (i_config_valid) begin
                r_mask <= i_output_enable_mask;
                r_ptr  <= w_cfg_ptr;
            end else if (w_dispatch) begin
                r_ptr  <= w_next_ptr;
            end
            if (w_overflow_event) begin
                r_overflow <= 1'b1;
            end
            if (w_dispatch) begin
                r_dispatch_count <= r_dispatch_count + 32'd1;
            end
        end
    end

    // A return and a dispatch on the same output cancel each other out.
    // A return to a full counter saturates.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!resetn) begin
                r_credit[k] <= CREDIT_FULL;
            end else if (i_credit_return[k] && !w_dec_vec[k]) begin
                if (!w_full_vec[k]) begin
                    r_credit[k] <= r_credit[k] + CRW'(1);
                end
            end else if (!i_credit_return[k] && w_dec_vec[k]) begin
                r_credit[k] <= r_credit[k] - CRW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tree input stage and valid-alignment pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn || !w_dispatch) begin
            r_tree_input <= '0;
            r_tree_code  <= '0;
            r_tree_valid <= 1'b0;
        end else begin
            r_tree_input <= i_input;
            r_tree_code  <= r_ptr;
            r_tree_valid <= 1'b1;
        end
    end

    // One stage per tree level, so each bit leaves at the same moment as
    // the word it belongs to leaves the tree.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < LV; i++) begin
                r_valid_pipe[i] <= '0;
            end
        end else begin
            r_valid_pipe[0] <= w_tree_onehot;
            for (int i = 1; i < LV; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
            end
        end
    end

    assign o_input_ready       = w_ready;
    assign o_tree_input        = r_tree_input;
    assign o_tree_routing_code = r_tree_code;
    assign o_tree_valid        = r_tree_valid;
    assign o_output_valid      = r_valid_pipe[LV-1];
    assign o_credit_overflow   = r_overflow;
    assign o_dispatch_count    = r_dispatch_count;

endmodule

// File: tb/tb_routing_tree_dispatcher.sv
// Bench for routing_tree_dispatcher (N=16, 8-bit words, depth-4 credits).
// A directed table is followed by randomized cycles. Each cycle is compared
// against a reference model that tracks credits per output with integers and
// schedules the expected tree/valid outputs by absolute cycle number.
module tb_routing_tree_dispatcher;
    localparam int N    = 16;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_config_valid;
    logic [N-1:0]  i_output_enable_mask;
    logic          i_input_valid;
    logic [W-1:0]  i_input;
    logic          o_input_ready;
    logic [N-1:0]  i_credit_return;
    logic [W-1:0]  o_tree_input;
    logic [3:0]    o_tree_routing_code;
    logic          o_tree_valid;
    logic [N-1:0]  o_output_valid;
    logic          o_stall;
    logic          o_credit_overflow;
    logic [31:0]   o_dispatch_count;
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
    logic [31:0]   o_skip_count;
`endif

    always #5 clk = ~clk;

    routing_tree_dispatcher #(
        .INPUT_WORD_BIT_WIDTH(W),
        .NUMBER_OF_ROUTING_TREE_OUTPUTS(N),
        .CREDIT_DEPTH(D)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_config_valid(i_config_valid),
        .i_output_enable_mask(i_output_enable_mask),
        .i_input_valid(i_input_valid),
        .i_input(i_input),
        .o_input_ready(o_input_ready),
        .i_credit_return(i_credit_return),
        .o_tree_input(o_tree_input),
        .o_tree_routing_code(o_tree_routing_code),
        .o_tree_valid(o_tree_valid),
        .o_output_valid(o_output_valid),
        .o_stall(o_stall),
        .o_credit_overflow(o_credit_overflow),
        .o_dispatch_count(o_dispatch_count)
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
        ,
        .o_skip_count(o_skip_count)
`endif
    );

    typedef struct {
        logic         rstn;
        logic         cfg_v;
        logic [N-1:0] cfg_m;
        logic         in_v;
        logic [W-1:0] in_d;
        logic [N-1:0] cret;
        logic         use_tbl;
        logic         exp_ready;
        int           exp_count;
        int           exp_skip;
    } vec_t;

    vec_t tbl[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference model state
    logic [N-1:0] m_mask;
    int           m_credit [N];
    int           m_ptr;
    logic         m_stall;
    logic         m_ovf;
    logic [31:0]  m_count;
    logic [31:0]  m_skip;
    logic         sv_v  [MAXC];
    logic [W-1:0] sv_d  [MAXC];
    logic [3:0]   sv_c  [MAXC];
    logic [N-1:0] sv_ov [MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic void add(input logic rstn, input logic cfg_v, input logic [N-1:0] cfg_m,
                                input logic in_v, input logic [W-1:0] in_d,
                                input logic [N-1:0] cret, input logic exp_ready,
                                input int exp_count = -1, input int exp_skip = -1);
        vec_t v;
        v.rstn = rstn; v.cfg_v = cfg_v; v.cfg_m = cfg_m; v.in_v = in_v; v.in_d = in_d;
        v.cret = cret; v.use_tbl = 1'b1; v.exp_ready = exp_ready;
        v.exp_count = exp_count; v.exp_skip = exp_skip;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        m_mask  = '1;
        for (int k = 0; k < N; k++) m_credit[k] = D;
        m_ptr   = 0;
        m_stall = 1'b0;
        m_ovf   = 1'b0;
        m_count = '0;
        m_skip  = '0;
        for (int i = cyc + 1; i < MAXC; i++) begin
            sv_v[i] = 1'b0; sv_d[i] = '0; sv_c[i] = '0; sv_ov[i] = '0;
        end
    endtask

    task automatic run_row(input vec_t v);
        logic exp_ready, xfer, skip, disp, inc, dec;
        int   np;
        resetn               = v.rstn;
        i_config_valid       = v.cfg_v;
        i_output_enable_mask = v.cfg_m;
        i_input_valid        = v.in_v;
        i_input              = v.in_d;
        i_credit_return      = v.cret;
        @(negedge clk);
        exp_ready = v.rstn && (m_mask != '0) && (m_credit[m_ptr] > 0) && !v.cfg_v;
        chk("ready", o_input_ready, exp_ready);
        if (v.use_tbl) chk("tbl_ready", o_input_ready, v.exp_ready);
        chk("stall", o_stall, m_stall);
        chk("tree_valid", o_tree_valid, sv_v[cyc]);
        chk("tree_input", o_tree_input, sv_d[cyc]);
        if (sv_v[cyc]) chk("tree_code", o_tree_routing_code, sv_c[cyc]);
        chk("output_valid", o_output_valid, sv_ov[cyc]);
        chk("dispatch_count", o_dispatch_count, m_count);
        chk("credit_overflow", o_credit_overflow, m_ovf);
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
        chk("skip_count", o_skip_count, m_skip);
        if (v.exp_skip >= 0) chk("tbl_skip", o_skip_count, v.exp_skip);
`endif
        if (v.exp_count >= 0) chk("tbl_count", o_dispatch_count, v.exp_count);

        if (!v.rstn) begin
            model_reset();
        end else begin
            xfer = v.in_v && exp_ready;
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
            skip = xfer && (v.in_d == '0);
`else
            skip = 1'b0;
`endif
            disp    = xfer && !skip;
            m_stall = v.in_v && (m_mask != '0) && (m_credit[m_ptr] == 0);
            for (int k = 0; k < N; k++) begin
                inc = v.cret[k];
                dec = disp && (m_ptr == k);
                if (inc && !dec) begin
                    if (m_credit[k] == D) m_ovf = 1'b1;
                    else m_credit[k] = m_credit[k] + 1;
                end else if (dec && !inc) begin
                    m_credit[k] = m_credit[k] - 1;
                end
            end
            if (disp) begin
                sv_v[cyc+1]  = 1'b1;
                sv_d[cyc+1]  = v.in_d;
                sv_c[cyc+1]  = 4'(m_ptr);
                sv_ov[cyc+5] = sv_ov[cyc+5] | (N'(1) << m_ptr);
                m_count      = m_count + 1;
                np = m_ptr;
                for (int i = N; i >= 1; i--) begin
                    if (m_mask[(m_ptr + i) % N]) np = (m_ptr + i) % N;
                end
                m_ptr = np;
            end
            if (skip) m_skip = m_skip + 1;
            if (v.cfg_v) begin
                m_mask = v.cfg_m;
                m_ptr  = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (v.cfg_m[i]) m_ptr = i;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t rv;
        int   sel;

        // T1: reset state, 16 back-to-back words to every output
        add(0, 0, '0, 0, 0, '0, 0);
        for (int k = 0; k < 16; k++) add(1, 0, '0, 1, W'(k + 1), '0, 1);
        for (int k = 0; k < 6; k++)  add(1, 0, '0, 0, 0, '0, 1, (k == 5) ? 16 : -1);
        // T2: two outputs, credits run out, one credit returned
        add(0, 0, '0, 0, 0, '0, 0);
        add(1, 1, 16'h0011, 0, 0, '0, 0);
        for (int k = 0; k < 8; k++) add(1, 0, '0, 1, W'(8'h20 + k), '0, 1);
        add(1, 0, '0, 1, 8'h30, '0, 0);
        add(1, 0, '0, 1, 8'h30, '0, 0);
        add(1, 0, '0, 1, 8'h30, 16'h0001, 0);
        add(1, 0, '0, 1, 8'h31, '0, 1);
        add(1, 0, '0, 1, 8'h32, '0, 0);
        add(1, 0, '0, 0, 0, '0, 0);
        // T3: empty mask blocks, then a single-output mask
        add(1, 1, 16'h0000, 0, 0, '0, 0);
        for (int k = 0; k < 4; k++) add(1, 0, '0, 1, 8'h40, '0, 0);
        add(1, 1, 16'h0100, 0, 0, '0, 0);
        add(1, 0, '0, 1, 8'h88, '0, 1);
        add(1, 0, '0, 0, 0, '0, 1);
        // T4: same-cycle return and dispatch cancel; return to full overflows
        add(1, 1, 16'h0008, 0, 0, '0, 0);
        add(1, 0, '0, 1, 8'h51, '0, 1);
        add(1, 0, '0, 1, 8'h52, '0, 1);
        add(1, 0, '0, 1, 8'h53, 16'h0008, 1);
        add(1, 0, '0, 0, 0, 16'h0020, 1);
        add(1, 0, '0, 1, 8'h54, '0, 1);
        add(1, 0, '0, 1, 8'h55, '0, 1);
        add(1, 0, '0, 1, 8'h56, '0, 0);
        add(1, 0, '0, 0, 0, '0, 0);
        // T5: reset with words in flight; credits restored afterwards
        add(0, 0, '0, 0, 0, '0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, '0, 1, W'(8'h61 + k), '0, 1);
        add(0, 0, '0, 1, 8'h70, '0, 0);
        for (int k = 0; k < 7; k++) add(1, 0, '0, 0, 0, '0, 1, (k == 0) ? 0 : -1);
        add(1, 1, 16'h0001, 0, 0, '0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, '0, 1, W'(8'h71 + k), '0, (k < 4) ? 1'b1 : 1'b0);
`ifdef ROUTING_DISPATCH_ZERO_SKIP_EN
        // T6: zero words consumed but not dispatched
        add(0, 0, '0, 0, 0, '0, 0);
        add(1, 0, '0, 1, 8'h00, '0, 1);
        add(1, 0, '0, 1, 8'h05, '0, 1);
        add(1, 0, '0, 1, 8'h00, '0, 1);
        add(1, 0, '0, 1, 8'h07, '0, 1);
        for (int k = 0; k < 6; k++) add(1, 0, '0, 0, 0, '0, 1, (k == 5) ? 2 : -1, (k == 5) ? 2 : -1);
`endif

        // clock/reset block
        resetn = 1'b0; i_config_valid = 1'b0; i_output_enable_mask = '0;
        i_input_valid = 1'b0; i_input = '0; i_credit_return = '0;
        for (int i = 0; i < MAXC; i++) begin
            sv_v[i] = 1'b0; sv_d[i] = '0; sv_c[i] = '0; sv_ov[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[i]) run_row(tbl[i]);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            rv.rstn  = ($urandom_range(0, 199) != 0);
            rv.cfg_v = ($urandom_range(0, 29) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rv.cfg_m = N'($urandom());
                1:       rv.cfg_m = N'(1) << $urandom_range(0, N - 1);
                2:       rv.cfg_m = 16'hffff;
                default: rv.cfg_m = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'h0f0f;
            endcase
            rv.in_v = ($urandom_range(0, 3) != 0);
            rv.in_d = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom());
            rv.cret = '0;
            for (int k = 0; k < N; k++) rv.cret[k] = ($urandom_range(0, 5) == 0);
            rv.use_tbl   = 1'b0;
            rv.exp_ready = 1'b0;
            rv.exp_count = -1;
            rv.exp_skip  = -1;
            run_row(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
